// File: rtl/plab5_mcore_mem_req_arb_pkg.sv
// Shared constants and width helpers for the two-port memory request arbiter.
// Control layouts follow the VC mem msgs: req {type,opaque,addr,len}, resp {type,opaque,len}.
package plab5_mcore_mem_req_arb_pkg;

  localparam int unsigned TYPE_NBITS = 3;

  localparam logic DOM_PUB = 1'b0;
  localparam logic DOM_SEC = 1'b1;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2
  } mem_type_e;

  typedef enum logic {
    PORT_PUB = 1'b0,
    PORT_SEC = 1'b1
  } port_id_e;

  function automatic int unsigned len_nbits(input int unsigned d);
    return (d / 8 > 1) ? $clog2(d / 8) : 1;
  endfunction

  function automatic int unsigned req_cnbits(input int unsigned o, input int unsigned a,
                                             input int unsigned d);
    return TYPE_NBITS + o + a + len_nbits(d);
  endfunction

  function automatic int unsigned resp_cnbits(input int unsigned o, input int unsigned d);
    return TYPE_NBITS + o + len_nbits(d);
  endfunction

  // The port tag lives in the top bit of the opaque field.
  function automatic int unsigned tag_bit(input int unsigned o);
    return o - 1;
  endfunction

  function automatic int unsigned req_tag_pos(input int unsigned o, input int unsigned a,
                                              input int unsigned d);
    return len_nbits(d) + a + tag_bit(o);
  endfunction

  function automatic int unsigned resp_tag_pos(input int unsigned o, input int unsigned d);
    return len_nbits(d) + tag_bit(o);
  endfunction

  function automatic int unsigned cnt_nbits(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_arb_if.sv
// Generic val/rdy message channel carrying control, data and a domain bit.
interface plab5_mcore_mem_req_arb_if #(
  parameter int unsigned p_cnbits = 45,
  parameter int unsigned p_dnbits = 32
);

  logic                val;
  logic                rdy;
  logic [p_cnbits-1:0] control;
  logic [p_dnbits-1:0] data;
  logic                domain;

  modport master (output val, control, data, domain, input rdy);
  modport slave  (input val, control, data, domain, output rdy);

endinterface

// File: rtl/plab5_mcore_rr_arb2.sv
// Two-input grant selection with a round-robin priority pointer.
// With PLAB5_MCORE_ARB_FIXED_PRIO_EN defined the secure port always wins and no pointer exists.
module plab5_mcore_rr_arb2
  import plab5_mcore_mem_req_arb_pkg::*;
(
  input  logic [1:0] eligible,
  output port_id_e   grant
`ifndef PLAB5_MCORE_ARB_FIXED_PRIO_EN
  ,
  input  logic       clk,
  input  logic       reset,
  input  logic       advance
`endif
);

`ifdef PLAB5_MCORE_ARB_FIXED_PRIO_EN

  always_comb begin
    grant = PORT_PUB;
    if (eligible[1]) grant = PORT_SEC;
  end

`else

  port_id_e rr_ptr;

  // Pointer moves to the port that did not just win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= PORT_PUB;
    end else if (advance) begin
      rr_ptr <= (grant == PORT_PUB) ? PORT_SEC : PORT_PUB;
    end
  end

  always_comb begin
    grant = PORT_PUB;
    if (&eligible) begin
      grant = rr_ptr;
    end else if (eligible[1]) begin
      grant = PORT_SEC;
    end
  end

`endif

endmodule

// File: rtl/plab5_mcore_mem_req_arb.sv
// Two-port arbiter in front of the unified test memory with response demux by opaque tag.
// Define PLAB5_MCORE_ARB_FIXED_PRIO_EN to give the secure port fixed priority.
module plab5_mcore_mem_req_arb
  import plab5_mcore_mem_req_arb_pkg::*;
#(
  parameter int unsigned p_opaque_nbits    = 8,
  parameter int unsigned p_addr_nbits      = 32,
  parameter int unsigned p_data_nbits      = 32,
  parameter int unsigned p_max_outstanding = 2
) (
  input logic                         clk,
  input logic                         reset,
  plab5_mcore_mem_req_arb_if.slave    req0,
  plab5_mcore_mem_req_arb_if.slave    req1,
  plab5_mcore_mem_req_arb_if.master   memreq,
  plab5_mcore_mem_req_arb_if.slave    memresp,
  plab5_mcore_mem_req_arb_if.master   resp0,
  plab5_mcore_mem_req_arb_if.master   resp1
);

  localparam int unsigned c_req_cnbits  = req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
  localparam int unsigned c_resp_cnbits = resp_cnbits(p_opaque_nbits, p_data_nbits);
  localparam int unsigned c_req_tag     = req_tag_pos(p_opaque_nbits, p_addr_nbits, p_data_nbits);
  localparam int unsigned c_resp_tag    = resp_tag_pos(p_opaque_nbits, p_data_nbits);
  localparam int unsigned c_cnt_nbits   = cnt_nbits(p_max_outstanding);

  localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_outstanding);

  logic                     out_full;
  logic [c_req_cnbits-1:0]  slot_control;
  logic [p_data_nbits-1:0]  slot_data;
  logic                     slot_domain;

  logic [c_cnt_nbits-1:0]   cnt0;
  logic [c_cnt_nbits-1:0]   cnt1;

  logic                     room0;
  logic                     room1;
  logic                     slot_free;
  logic [1:0]               eligible;
  port_id_e                 grant;
  logic                     accept0;
  logic                     accept1;
  logic                     accept;
  logic                     fire;
  logic [c_req_cnbits-1:0]  in_control;
  logic [p_data_nbits-1:0]  in_data;

  logic                     sel;
  logic                     leak;
  logic [c_resp_cnbits-1:0] resp_control;
  logic                     resp_fire0;
  logic                     resp_fire1;

  assign room0     = (cnt0 < c_max);
  assign room1     = (cnt1 < c_max);
  assign slot_free = !out_full || memreq.rdy;
  assign eligible  = {req1.val && room1, req0.val && room0};

  plab5_mcore_rr_arb2 arb (
    .eligible (eligible),
    .grant    (grant)
`ifndef PLAB5_MCORE_ARB_FIXED_PRIO_EN
    ,
    .clk      (clk),
    .reset    (reset),
    .advance  (accept)
`endif
  );

  assign req0.rdy = reset && slot_free && room0 && (grant == PORT_PUB);
  assign req1.rdy = reset && slot_free && room1 && (grant == PORT_SEC);

  assign accept0 = req0.val && req0.rdy;
  assign accept1 = req1.val && req1.rdy;
  assign accept  = accept0 || accept1;
  assign fire    = memreq.val && memreq.rdy;

  // The winning port's id overwrites the opaque MSB so responses can be steered back.
  always_comb begin
    in_control            = (grant == PORT_SEC) ? req1.control : req0.control;
    in_data               = (grant == PORT_SEC) ? req1.data    : req0.data;
    in_control[c_req_tag] = grant;
  end

  // A fire and an accept in the same cycle refill the slot, sustaining one request per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_full     <= 1'b0;
      slot_control <= '0;
      slot_data    <= '0;
      slot_domain  <= DOM_PUB;
    end else if (accept) begin
      out_full     <= 1'b1;
      slot_control <= in_control;
      slot_data    <= in_data;
      slot_domain  <= grant;
    end else if (fire) begin
      out_full     <= 1'b0;
    end
  end

  assign memreq.val     = out_full;
  assign memreq.control = slot_control;
  assign memreq.data    = slot_data;
  assign memreq.domain  = slot_domain;

  // Responses whose domain disagrees with their tag keep control but lose data.
  always_comb begin
    sel                      = memresp.control[c_resp_tag];
    leak                     = (memresp.domain != sel);
    resp_control             = memresp.control;
    resp_control[c_resp_tag] = 1'b0;
  end

  assign resp0.val     = reset && memresp.val && !sel;
  assign resp1.val     = reset && memresp.val &&  sel;
  assign memresp.rdy   = reset && (sel ? resp1.rdy : resp0.rdy);

  assign resp0.control = resp_control;
  assign resp1.control = resp_control;
  assign resp0.data    = leak ? '0 : memresp.data;
  assign resp1.data    = leak ? '0 : memresp.data;
  assign resp0.domain  = DOM_PUB;
  assign resp1.domain  = DOM_SEC;

  assign resp_fire0 = resp0.val && resp0.rdy;
  assign resp_fire1 = resp1.val && resp1.rdy;

  // Saturating at zero covers responses still in flight across a reset.
  function automatic logic [c_cnt_nbits-1:0] next_cnt(input logic [c_cnt_nbits-1:0] cnt,
                                                      input logic inc, input logic dec);
    logic [c_cnt_nbits-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + c_cnt_nbits'(1);
    end else if (!inc && dec && (cnt != '0)) begin
      nxt = cnt - c_cnt_nbits'(1);
    end
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= next_cnt(cnt0, accept0, resp_fire0);
      cnt1 <= next_cnt(cnt1, accept1, resp_fire1);
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_arb.sv
// Directed bench for the two-port memory request arbiter and response demux.
// Grant order expectations follow PLAB5_MCORE_ARB_FIXED_PRIO_EN when it is defined.
module tb_plab5_mcore_mem_req_arb;
  import plab5_mcore_mem_req_arb_pkg::*;

  localparam int unsigned O       = 8;
  localparam int unsigned A       = 32;
  localparam int unsigned D       = 32;
  localparam int unsigned MAXO    = 2;
  localparam int unsigned REQ_CN  = 45;
  localparam int unsigned RESP_CN = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab5_mcore_mem_req_arb_if #(.p_cnbits(REQ_CN),  .p_dnbits(D)) req0_if ();
  plab5_mcore_mem_req_arb_if #(.p_cnbits(REQ_CN),  .p_dnbits(D)) req1_if ();
  plab5_mcore_mem_req_arb_if #(.p_cnbits(REQ_CN),  .p_dnbits(D)) memreq_if ();
  plab5_mcore_mem_req_arb_if #(.p_cnbits(RESP_CN), .p_dnbits(D)) memresp_if ();
  plab5_mcore_mem_req_arb_if #(.p_cnbits(RESP_CN), .p_dnbits(D)) resp0_if ();
  plab5_mcore_mem_req_arb_if #(.p_cnbits(RESP_CN), .p_dnbits(D)) resp1_if ();

  plab5_mcore_mem_req_arb #(
    .p_opaque_nbits    (O),
    .p_addr_nbits      (A),
    .p_data_nbits      (D),
    .p_max_outstanding (MAXO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0_if),
    .req1    (req1_if),
    .memreq  (memreq_if),
    .memresp (memresp_if),
    .resp0   (resp0_if),
    .resp1   (resp1_if)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [REQ_CN-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr);
    return {3'd0, op, addr, 2'b00};
  endfunction

  function automatic logic [RESP_CN-1:0] mk_resp(input logic [7:0] op);
    return {3'd0, op, 2'b00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_if.val = 1'b0;  req0_if.control = '0;  req0_if.data = '0;  req0_if.domain = 1'b0;
    req1_if.val = 1'b0;  req1_if.control = '0;  req1_if.data = '0;  req1_if.domain = 1'b1;
    memreq_if.rdy = 1'b1;
    memresp_if.val = 1'b0; memresp_if.control = '0; memresp_if.data = '0; memresp_if.domain = 1'b0;
    resp0_if.rdy = 1'b1;
    resp1_if.rdy = 1'b1;
  endtask

  // Deliver one matching-domain response to a port and check its routing.
  task automatic do_resp(input logic port, input logic [6:0] op, input logic [31:0] data);
    memresp_if.val = 1'b1; memresp_if.control = mk_resp({port, op});
    memresp_if.data = data; memresp_if.domain = port;
    #1;
    checks++; if (resp0_if.val !== !port) begin errors++; $display("[TB] FAIL resp_route0 got %b expected %b", resp0_if.val, !port); end
    checks++; if (resp1_if.val !== port) begin errors++; $display("[TB] FAIL resp_route1 got %b expected %b", resp1_if.val, port); end
    if (port) begin
      checks++; if (resp1_if.control !== mk_resp({1'b0, op})) begin errors++; $display("[TB] FAIL resp1_control got %h expected %h", resp1_if.control, mk_resp({1'b0, op})); end
      checks++; if (resp1_if.data !== data) begin errors++; $display("[TB] FAIL resp1_data got %h expected %h", resp1_if.data, data); end
    end else begin
      checks++; if (resp0_if.control !== mk_resp({1'b0, op})) begin errors++; $display("[TB] FAIL resp0_control got %h expected %h", resp0_if.control, mk_resp({1'b0, op})); end
      checks++; if (resp0_if.data !== data) begin errors++; $display("[TB] FAIL resp0_data got %h expected %h", resp0_if.data, data); end
    end
    checks++; if (memresp_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL memresp_rdy got %b expected 1", memresp_if.rdy); end
    tick();
    memresp_if.val = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    req0_if.val = 1'b1; req1_if.val = 1'b1;
    memresp_if.val = 1'b1; memresp_if.control = mk_resp(8'h85);
    tick(); tick();
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL reset_memreq_val got %b expected 0", memreq_if.val); end
    checks++; if (req0_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_rdy got %b expected 0", req0_if.rdy); end
    checks++; if (req1_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_rdy got %b expected 0", req1_if.rdy); end
    checks++; if (resp0_if.val !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp0_val got %b expected 0", resp0_if.val); end
    checks++; if (resp1_if.val !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp1_val got %b expected 0", resp1_if.val); end
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_memreq_val got %b expected 0", memreq_if.val); end
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req0_rdy got %b expected 1", req0_if.rdy); end
  endtask

  task automatic test_single_port0();
    req0_if.val = 1'b1; req0_if.control = mk_req(8'h05, 32'h0000_0004); req0_if.data = 32'hA5A5_0001;
    #1;
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_req0_rdy got %b expected 1", req0_if.rdy); end
    tick();
    req0_if.val = 1'b0;
    checks++; if (memreq_if.val !== 1'b1) begin errors++; $display("[TB] FAIL single_memreq_val got %b expected 1", memreq_if.val); end
    checks++; if (memreq_if.control !== mk_req(8'h05, 32'h4)) begin errors++; $display("[TB] FAIL single_memreq_control got %h expected %h", memreq_if.control, mk_req(8'h05, 32'h4)); end
    checks++; if (memreq_if.data !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL single_memreq_data got %h expected a5a50001", memreq_if.data); end
    checks++; if (memreq_if.domain !== 1'b0) begin errors++; $display("[TB] FAIL single_memreq_domain got %b expected 0", memreq_if.domain); end
    tick();
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL single_drain_val got %b expected 0", memreq_if.val); end
    do_resp(1'b0, 7'h05, 32'h0000_1234);
  endtask

  task automatic test_alternate();
    logic seq [4];
`ifdef PLAB5_MCORE_ARB_FIXED_PRIO_EN
    seq = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    req0_if.val = 1'b1; req0_if.control = mk_req(8'h10, 32'h100); req0_if.data = 32'h0000_0100;
    req1_if.val = 1'b1; req1_if.control = mk_req(8'h20, 32'h200); req1_if.data = 32'h0000_0200;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req0_if.rdy !== !seq[k]) begin errors++; $display("[TB] FAIL alt_req0_rdy step %0d got %b expected %b", k, req0_if.rdy, !seq[k]); end
      checks++; if (req1_if.rdy !== seq[k]) begin errors++; $display("[TB] FAIL alt_req1_rdy step %0d got %b expected %b", k, req1_if.rdy, seq[k]); end
      tick();
      checks++; if (memreq_if.domain !== seq[k]) begin errors++; $display("[TB] FAIL alt_domain step %0d got %b expected %b", k, memreq_if.domain, seq[k]); end
      checks++; if (memreq_if.control[41:34] !== (seq[k] ? 8'hA0 : 8'h10)) begin errors++; $display("[TB] FAIL alt_opaque step %0d got %h expected %h", k, memreq_if.control[41:34], seq[k] ? 8'hA0 : 8'h10); end
    end
    checks++; if (req0_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL alt_full_req0_rdy got %b expected 0", req0_if.rdy); end
    checks++; if (req1_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL alt_full_req1_rdy got %b expected 0", req1_if.rdy); end
    req0_if.val = 1'b0; req1_if.val = 1'b0;
    tick();
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL alt_drain_val got %b expected 0", memreq_if.val); end
    do_resp(1'b1, 7'h20, 32'h0000_2000);
    do_resp(1'b1, 7'h20, 32'h0000_2001);
    do_resp(1'b0, 7'h10, 32'h0000_1000);
    do_resp(1'b0, 7'h10, 32'h0000_1001);
  endtask

  task automatic test_backpressure();
    memreq_if.rdy = 1'b0;
    req0_if.val = 1'b1; req0_if.control = mk_req(8'h31, 32'h300); req0_if.data = 32'h0000_0300;
    #1;
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_rdy got %b expected 1", req0_if.rdy); end
    tick();
    req0_if.control = mk_req(8'hB2, 32'h304); req0_if.data = 32'h0000_0304;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req0_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_rdy cycle %0d got %b expected 0", i, req0_if.rdy); end
      checks++; if (memreq_if.val !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall_val cycle %0d got %b expected 1", i, memreq_if.val); end
      checks++; if (memreq_if.control !== mk_req(8'h31, 32'h300)) begin errors++; $display("[TB] FAIL bp_stall_control cycle %0d got %h expected %h", i, memreq_if.control, mk_req(8'h31, 32'h300)); end
      tick();
    end
    memreq_if.rdy = 1'b1;
    #1;
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_rdy got %b expected 1", req0_if.rdy); end
    tick();
    req0_if.val = 1'b0;
    checks++; if (memreq_if.val !== 1'b1) begin errors++; $display("[TB] FAIL bp_refill_val got %b expected 1", memreq_if.val); end
    checks++; if (memreq_if.control !== mk_req(8'h32, 32'h304)) begin errors++; $display("[TB] FAIL bp_refill_control got %h expected %h", memreq_if.control, mk_req(8'h32, 32'h304)); end
    tick();
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_val got %b expected 0", memreq_if.val); end
    do_resp(1'b0, 7'h31, 32'h0000_3100);
    do_resp(1'b0, 7'h32, 32'h0000_3200);
  endtask

  task automatic test_max_outstanding();
    req1_if.val = 1'b1; req1_if.control = mk_req(8'h11, 32'h400); req1_if.data = 32'h0000_0400;
    #1;
    checks++; if (req1_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL max_first_rdy got %b expected 1", req1_if.rdy); end
    tick();
    checks++; if (req1_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL max_second_rdy got %b expected 1", req1_if.rdy); end
    tick();
    checks++; if (memreq_if.control[41:34] !== 8'h91) begin errors++; $display("[TB] FAIL max_opaque_tag got %h expected 91", memreq_if.control[41:34]); end
    checks++; if (req1_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL max_limit_rdy got %b expected 0", req1_if.rdy); end
    req0_if.val = 1'b1; req0_if.control = mk_req(8'h12, 32'h500); req0_if.data = 32'h0000_0500;
    #1;
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL max_port0_rdy got %b expected 1", req0_if.rdy); end
    tick();
    req0_if.val = 1'b0;
    checks++; if (memreq_if.domain !== 1'b0) begin errors++; $display("[TB] FAIL max_port0_domain got %b expected 0", memreq_if.domain); end
    memresp_if.val = 1'b1; memresp_if.control = mk_resp(8'h91); memresp_if.domain = 1'b1; memresp_if.data = 32'h0000_9100;
    #1;
    checks++; if (req1_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL max_during_resp_rdy got %b expected 0", req1_if.rdy); end
    tick();
    memresp_if.val = 1'b0;
    #1;
    checks++; if (req1_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL max_after_resp_rdy got %b expected 1", req1_if.rdy); end
    req1_if.val = 1'b0;
    tick();
    do_resp(1'b1, 7'h11, 32'h0000_1100);
    do_resp(1'b0, 7'h12, 32'h0000_1200);
  endtask

  task automatic test_domain_mismatch();
    resp1_if.rdy = 1'b0;
    memresp_if.val = 1'b1; memresp_if.control = mk_resp(8'h83);
    memresp_if.domain = 1'b0; memresp_if.data = 32'hDEAD_BEEF;
    #1;
    checks++; if (resp1_if.val !== 1'b1) begin errors++; $display("[TB] FAIL mis_resp1_val got %b expected 1", resp1_if.val); end
    checks++; if (resp0_if.val !== 1'b0) begin errors++; $display("[TB] FAIL mis_resp0_val got %b expected 0", resp0_if.val); end
    checks++; if (resp1_if.control !== mk_resp(8'h03)) begin errors++; $display("[TB] FAIL mis_resp1_control got %h expected %h", resp1_if.control, mk_resp(8'h03)); end
    checks++; if (resp1_if.data !== 32'h0) begin errors++; $display("[TB] FAIL mis_resp1_data got %h expected 0", resp1_if.data); end
    checks++; if (memresp_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL mis_memresp_rdy_low got %b expected 0", memresp_if.rdy); end
    resp1_if.rdy = 1'b1;
    #1;
    checks++; if (memresp_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL mis_memresp_rdy_high got %b expected 1", memresp_if.rdy); end
    tick();
    memresp_if.val = 1'b0;
    // Counter must have stayed at zero: exactly two more requests fit.
    req1_if.val = 1'b1; req1_if.control = mk_req(8'h40, 32'h600);
    #1;
    checks++; if (req1_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL sat_first_rdy got %b expected 1", req1_if.rdy); end
    tick();
    checks++; if (req1_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL sat_second_rdy got %b expected 1", req1_if.rdy); end
    tick();
    checks++; if (req1_if.rdy !== 1'b0) begin errors++; $display("[TB] FAIL sat_limit_rdy got %b expected 0", req1_if.rdy); end
    req1_if.val = 1'b0;
    tick();
    do_resp(1'b1, 7'h40, 32'h0000_4000);
    do_resp(1'b1, 7'h40, 32'h0000_4001);
  endtask

  task automatic test_mid_reset();
    memreq_if.rdy = 1'b0;
    req0_if.val = 1'b1; req0_if.control = mk_req(8'h50, 32'h700);
    tick();
    req0_if.val = 1'b0;
    checks++; if (memreq_if.val !== 1'b1) begin errors++; $display("[TB] FAIL midrst_loaded_val got %b expected 1", memreq_if.val); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    memreq_if.rdy = 1'b1;
    checks++; if (memreq_if.val !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cleared_val got %b expected 0", memreq_if.val); end
    do_resp(1'b0, 7'h50, 32'h0000_5000);
    req0_if.val = 1'b1;
    #1;
    checks++; if (req0_if.rdy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_req0_rdy got %b expected 1", req0_if.rdy); end
    req0_if.val = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_port0();
    test_alternate();
    test_backpressure();
    test_max_outstanding();
    test_domain_mismatch();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
